// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types for the register-file writeback path: word/index types and the
// fixed writeback source numbering used by the scheduler and its clients.
package Types;

   typedef logic [31:0] word;
   typedef logic [4:0]  reg_idx_t;

   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned WB_SRC_ALU = 0;
   localparam int unsigned WB_SRC_LSU = 1;
   localparam int unsigned WB_SRC_CSR = 2;

   // One-hot decode of a register index into a scoreboard-sized mask.
   function automatic logic [NUM_REGS-1:0] reg_mask(input reg_idx_t idx);
      logic [NUM_REGS-1:0] m;
      m      = '0;
      m[idx] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after prio, cyclically,
// and moves prio one past the winner.
module rr_arbiter #(
   parameter int unsigned N = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
   localparam logic [PW:0]   NumW  = (PW + 1)'(N);
   localparam logic [PW-1:0] LastW = PW'(N - 1);

   logic [PW-1:0] prio_q, prio_d;
   logic [PW:0]   sum;
   logic [PW-1:0] idx;

   always_comb begin
      gnt    = '0;
      prio_d = prio_q;
      sum    = '0;
      idx    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         sum = {1'b0, prio_q} + (PW + 1)'(i);
         if (sum >= NumW) begin
            sum = sum - NumW;
         end
         idx = sum[PW-1:0];
         if (gnt == '0 && req[idx]) begin
            gnt[idx] = 1'b1;
            prio_d   = (idx == LastW) ? '0 : idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio_q <= '0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: round-robin writeback arbitration, a
// registered write stage and a busy scoreboard that stalls issue on RAW/WAW.
module regfile_wb_scheduler
   import Types::*;
#(
   parameter int unsigned NUM_SRC = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          issue_valid,
   input  logic [4:0]                    issue_rd,
   input  logic [4:0]                    issue_rs1,
   input  logic [4:0]                    issue_rs2,
   input  logic                          issue_writes_rd,
   output logic                          issue_stall,
   input  logic [NUM_SRC-1:0]            src_valid,
   input  logic [NUM_SRC-1:0][4:0]       src_rd,
   input  word  [NUM_SRC-1:0]            src_data,
   output logic [NUM_SRC-1:0]            src_ready,
   output logic [4:0]                    rd_index,
   output logic [31:0]                   rd_in,
   output logic                          rd_w,
   output logic                          wb_err
);

   logic [NUM_REGS-1:0] busy_q, busy_d;
   reg_idx_t            rd_index_q, rd_index_d;
   word                 rd_in_q, rd_in_d;
   logic                rd_w_q, rd_w_d;
   logic                wb_err_q, wb_err_d;

   logic [NUM_SRC-1:0]  arb_req, arb_gnt;
   logic                accept;
   reg_idx_t            sel_rd;
   word                 sel_data;
   logic                issue_fire;

   // Requests are masked in reset so no grant is visible and nothing is taken.
   assign arb_req = src_valid & {NUM_SRC{rst_n}};

   rr_arbiter #(
      .N (NUM_SRC)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (arb_req),
      .gnt   (arb_gnt)
   );

   assign src_ready = arb_gnt & {NUM_SRC{rst_n}};
   assign accept    = |src_ready;

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (src_ready[k]) begin
            sel_rd   = src_rd[k];
            sel_data = src_data[k];
         end
      end
   end

   assign issue_stall = issue_valid & (busy_q[issue_rs1] | busy_q[issue_rs2] |
                                       (issue_writes_rd & busy_q[issue_rd]));
   assign issue_fire  = issue_valid & ~issue_stall;

   always_comb begin
      busy_d     = busy_q;
      wb_err_d   = wb_err_q;
      rd_index_d = rd_index_q;
      rd_in_d    = rd_in_q;
      rd_w_d     = 1'b0;
      if (accept) begin
         rd_index_d = sel_rd;
         rd_in_d    = sel_data;
         rd_w_d     = (sel_rd != '0);
         if (sel_rd != '0 && !busy_q[sel_rd]) begin
            wb_err_d = 1'b1;
         end
         busy_d = busy_d & ~reg_mask(sel_rd);
      end
      // The set is applied after the clear so it wins on a shared index.
      if (issue_fire && issue_writes_rd && issue_rd != '0) begin
         busy_d = busy_d | reg_mask(issue_rd);
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q     <= '0;
         rd_index_q <= '0;
         rd_in_q    <= '0;
         rd_w_q     <= 1'b0;
         wb_err_q   <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         rd_index_q <= rd_index_d;
         rd_in_q    <= rd_in_d;
         rd_w_q     <= rd_w_d;
         wb_err_q   <= wb_err_d;
      end
   end

   assign rd_index = rd_index_q;
   assign rd_in    = rd_in_q;
   assign rd_w     = rd_w_q;
   assign wb_err   = wb_err_q;

   a_gnt_onehot : assert property (@(posedge clk) $onehot0(src_ready));
   a_gnt_valid  : assert property (@(posedge clk) (src_ready & ~src_valid) == '0);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: a reference model predicts grants,
// stalls and writebacks; expected writes are queued and popped one cycle later.
module tb_regfile_wb_scheduler;
   import Types::*;

   localparam int unsigned NUM_SRC = 3;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    issue_valid;
   logic [4:0]              issue_rd, issue_rs1, issue_rs2;
   logic                    issue_writes_rd;
   logic                    issue_stall;
   logic [NUM_SRC-1:0]      src_valid;
   logic [NUM_SRC-1:0][4:0] src_rd;
   word  [NUM_SRC-1:0]      src_data;
   logic [NUM_SRC-1:0]      src_ready;
   logic [4:0]              rd_index;
   logic [31:0]             rd_in;
   logic                    rd_w;
   logic                    wb_err;

   always #5 clk = ~clk;

   regfile_wb_scheduler #(
      .NUM_SRC (NUM_SRC)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .issue_valid     (issue_valid),
      .issue_rd        (issue_rd),
      .issue_rs1       (issue_rs1),
      .issue_rs2       (issue_rs2),
      .issue_writes_rd (issue_writes_rd),
      .issue_stall     (issue_stall),
      .src_valid       (src_valid),
      .src_rd          (src_rd),
      .src_data        (src_data),
      .src_ready       (src_ready),
      .rd_index        (rd_index),
      .rd_in           (rd_in),
      .rd_w            (rd_w),
      .wb_err          (wb_err)
   );

   typedef struct packed {
      logic [4:0] idx;
      word        data;
      logic       w;
   } wb_t;

   wb_t                exp_q[$];
   logic [31:0]        busy_m;
   int unsigned        prio_m;
   logic               err_m;
   logic [4:0]         hold_idx;
   word                hold_data;
   logic [NUM_SRC-1:0] last_gnt;
   logic               last_stall;
   int                 n_checks = 0;
   int                 n_fail = 0;
   word                rf [32];

   // Register file model: writes on the negedge of the cycle rd_w is high.
   always @(negedge clk) begin
      if (rd_w) rf[rd_index] <= rd_in;
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic idle();
      issue_valid     = 1'b0;
      issue_rd        = '0;
      issue_rs1       = '0;
      issue_rs2       = '0;
      issue_writes_rd = 1'b0;
      src_valid       = '0;
      src_rd          = '0;
      src_data        = '0;
   endtask

   // One clock: check combinational outputs mid-cycle, then registered ones after the edge.
   task automatic step();
      logic [NUM_SRC-1:0] g;
      logic               st;
      logic               pushed;
      logic [31:0]        nb;
      int unsigned        np;
      int unsigned        k;
      int unsigned        gk;
      logic               ne;
      wb_t                e;
      #2;
      g      = '0;
      gk     = 0;
      np     = prio_m;
      nb     = busy_m;
      ne     = err_m;
      pushed = 1'b0;
      e      = '0;
      if (rst_n) begin
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            k = (prio_m + i) % NUM_SRC;
            if (g == '0 && src_valid[k]) begin
               g[k] = 1'b1;
               gk   = k;
               np   = (k + 1) % NUM_SRC;
            end
         end
      end
      last_gnt = src_ready;
      check("src_ready", 64'(src_ready), 64'(g));
      st = issue_valid && (busy_m[issue_rs1] || busy_m[issue_rs2] ||
                           (issue_writes_rd && busy_m[issue_rd]));
      last_stall = issue_stall;
      check("issue_stall", 64'(issue_stall), 64'(st));
      if (g != '0) begin
         e.idx  = src_rd[gk];
         e.data = src_data[gk];
         e.w    = (src_rd[gk] != 5'd0);
         exp_q.push_back(e);
         pushed = 1'b1;
         if (e.w && !busy_m[e.idx]) ne = 1'b1;
         nb[e.idx] = 1'b0;
      end
      if (rst_n && issue_valid && !st && issue_writes_rd && issue_rd != 5'd0) begin
         nb[issue_rd] = 1'b1;
      end
      nb[0] = 1'b0;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         busy_m    = '0;
         prio_m    = 0;
         err_m     = 1'b0;
         hold_idx  = '0;
         hold_data = '0;
         exp_q.delete();
         check("rst_rd_w", 64'(rd_w), 64'(0));
      end else begin
         busy_m = nb;
         prio_m = np;
         err_m  = ne;
         if (pushed) begin
            e         = exp_q.pop_front();
            hold_idx  = e.idx;
            hold_data = e.data;
            check("wb_rd_w", 64'(rd_w), 64'(e.w));
         end else begin
            check("idle_rd_w", 64'(rd_w), 64'(0));
         end
      end
      check("rd_index", 64'(rd_index), 64'(hold_idx));
      check("rd_in", 64'(rd_in), 64'(hold_data));
      check("wb_err", 64'(wb_err), 64'(err_m));
      check("busy", 64'(dut.busy_q), 64'(busy_m));
   endtask

   logic [NUM_SRC-1:0] rr_order [6];

   initial begin
      rr_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      busy_m    = '0;
      prio_m    = 0;
      err_m     = 1'b0;
      hold_idx  = '0;
      hold_data = '0;
      for (int i = 0; i < 32; i++) rf[i] = '0;
      idle();

      // Reset then idle
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      check("reset_rd_w", 64'(rd_w), 64'(0));
      check("reset_rd_index", 64'(rd_index), 64'(0));
      check("reset_rd_in", 64'(rd_in), 64'(0));
      check("reset_wb_err", 64'(wb_err), 64'(0));
      check("reset_busy", 64'(dut.busy_q), 64'(0));
      check("reset_stall", 64'(last_stall), 64'(0));

      // RAW on x5 cleared by an LSU writeback
      issue_valid = 1'b1; issue_rd = 5'd5; issue_writes_rd = 1'b1;
      step();
      issue_rd = 5'd0; issue_writes_rd = 1'b0; issue_rs1 = 5'd5;
      step();
      check("raw_stall", 64'(last_stall), 64'(1));
      src_valid = 3'b010; src_rd[1] = 5'd5; src_data[1] = 32'hDEAD_BEEF;
      step();
      check("raw_wb_rd_w", 64'(rd_w), 64'(1));
      check("raw_wb_idx", 64'(rd_index), 64'(5));
      check("raw_wb_data", 64'(rd_in), 64'(32'hDEAD_BEEF));
      src_valid = '0;
      step();
      check("raw_stall_drop", 64'(last_stall), 64'(0));
      idle();
      check("raw_rf_read", 64'(rf[5]), 64'(32'hDEAD_BEEF));

      // Round-robin order from reset with all sources valid
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      src_valid = 3'b111;
      for (int i = 0; i < NUM_SRC; i++) src_data[i] = 32'hA000_0000 + 32'(i);
      for (int i = 0; i < 6; i++) begin
         step();
         check("rr_order", 64'(last_gnt), 64'(rr_order[i]));
         check("rr_onehot", 64'($onehot(last_gnt)), 64'(1));
      end
      idle();

      // WAW on x7
      issue_valid = 1'b1; issue_rd = 5'd7; issue_writes_rd = 1'b1;
      issue_rs1 = 5'd1; issue_rs2 = 5'd2;
      step();
      step();
      check("waw_stall", 64'(last_stall), 64'(1));
      issue_writes_rd = 1'b0;
      step();
      check("waw_no_write_stall", 64'(last_stall), 64'(0));
      idle();
      src_valid = 3'b001; src_rd[0] = 5'd7; src_data[0] = 32'h0000_0777;
      step();
      idle();
      step();

      // x0 writeback, then writeback to a non-busy register
      src_valid = 3'b001; src_rd[0] = 5'd0; src_data[0] = 32'h0000_1234;
      step();
      check("x0_rd_w", 64'(rd_w), 64'(0));
      check("x0_wb_err", 64'(wb_err), 64'(0));
      src_valid = 3'b100; src_rd[2] = 5'd9; src_data[2] = 32'h0000_0999;
      step();
      check("nb_rd_w", 64'(rd_w), 64'(1));
      check("nb_wb_err", 64'(wb_err), 64'(1));
      idle();
      step();
      step();
      check("err_sticky", 64'(wb_err), 64'(1));

      // Reset mid-operation with busy = 0x60 and the ALU valid
      issue_valid = 1'b1; issue_writes_rd = 1'b1; issue_rd = 5'd5;
      step();
      issue_rd = 5'd6;
      step();
      idle();
      check("pre_rst_busy", 64'(dut.busy_q), 64'(32'h0000_0060));
      rst_n = 1'b0;
      src_valid = 3'b001; src_rd[0] = 5'd5; src_data[0] = 32'h5555_5555;
      step();
      check("midrst_ready", 64'(last_gnt), 64'(0));
      check("midrst_busy", 64'(dut.busy_q), 64'(0));
      check("midrst_rd_w", 64'(rd_w), 64'(0));
      check("midrst_err", 64'(wb_err), 64'(0));
      rst_n = 1'b1;
      src_valid = 3'b111; src_rd = '0;
      step();
      check("post_rst_gnt0", 64'(last_gnt), 64'(3'b001));
      step();
      check("post_rst_gnt1", 64'(last_gnt), 64'(3'b010));
      idle();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
